mapper_ram_sequencer: RTL and testbench

- Downstream stage of the MegaRAM/ASCII/SCC cartridge mappers.
- Consumes the mapper's translated RAM request (address, chip-select, read-not-write) plus CPU write data.
- Runs one req/ack transaction on the shared cartridge-RAM port, stretches the CPU cycle with a wait signal, and returns read data.
- Sits between the mapper output and the SDRAM/BRAM arbiter port.

---
 rtl/mapper_ram_pkg.sv | 22 ++
 rtl/mapper_ram_rcache.sv | 45 ++++
 rtl/mapper_ram_sequencer.sv | 155 +++++++++++++++
 tb/tb_mapper_ram_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mapper_ram_pkg.sv
// rtl/mapper_ram_pkg.sv - shared states, constants and request type for the mapper RAM sequencer
package mapper_ram_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } seq_state_t;

  // Value presented on rdata after reset and after an aborted read
  localparam logic [7:0] RDATA_IDLE = 8'hFF;

  // Widest mapper address the request record can carry
  localparam int REQ_ADDR_W = 32;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic                  we;
    logic [7:0]            din;
  } ram_req_t;

endpackage

// File: rtl/mapper_ram_rcache.sv
// rtl/mapper_ram_rcache.sv - single-entry read cache with write-through update and flush
module mapper_ram_rcache #(
  parameter int ADDR_W = 27
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic              fill_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [7:0]        upd_data,
  output logic              hit,
  output logic [7:0]        hit_data
);

  logic              valid;
  logic [ADDR_W-1:0] tag;
  logic [7:0]        data;

  // Entry maintenance: fill on read completion, refresh data on a completed write to the
  // cached address; flush is applied last so it wins over a simultaneous fill
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= 8'h00;
    end else begin
      if (fill_en) begin
        valid <= 1'b1;
        tag   <= upd_addr;
        data  <= upd_data;
      end else if (wr_en && valid && (tag == upd_addr)) begin
        data <= upd_data;
      end
      if (flush) begin
        valid <= 1'b0;
      end
    end
  end

  assign hit      = valid && (tag == lookup_addr);
  assign hit_data = data;

endmodule

// File: rtl/mapper_ram_sequencer.sv
// rtl/mapper_ram_sequencer.sv - req/ack sequencer between cartridge mapper and RAM port (optional MAPPER_RAM_READ_CACHE_EN)
module mapper_ram_sequencer
  import mapper_ram_pkg::*;
#(
  parameter int ADDR_W      = 27,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              ram_cs,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  input  logic              flush,
  output logic              cpu_wait,
  output logic [7:0]        rdata,
  output logic              rdata_valid,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic              mem_ack,
  input  logic [7:0]        mem_dout
);

  seq_state_t  state, state_nxt;
  ram_req_t    req;
  logic [15:0] tmo_cnt;
  logic        accept, hit_take, ack_take, tmo_take;
  logic        hit;
  logic [7:0]  hit_data;
  logic        is_read;
  logic        unused_addr_hi;

  assign is_read        = ~req.we;
  assign mem_we         = req.we;
  assign mem_din        = req.din;
  assign mem_addr       = req.addr[ADDR_W-1:0];
  assign unused_addr_hi = ^req.addr;

`ifdef MAPPER_RAM_READ_CACHE_EN
  mapper_ram_rcache #(
    .ADDR_W (ADDR_W)
  ) u_rcache (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .lookup_addr (addr),
    .fill_en     (ack_take && is_read),
    .wr_en       (ack_take && req.we),
    .upd_addr    (req.addr[ADDR_W-1:0]),
    .upd_data    (is_read ? mem_dout : req.din),
    .hit         (hit),
    .hit_data    (hit_data)
  );
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign hit          = 1'b0;
  assign hit_data     = RDATA_IDLE;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, transaction events and the combinational CPU wait request
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    hit_take  = 1'b0;
    ack_take  = 1'b0;
    tmo_take  = 1'b0;
    cpu_wait  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && ram_cs) begin
          accept   = 1'b1;
          cpu_wait = 1'b1;
          if (rnw && hit) begin
            hit_take  = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        cpu_wait = 1'b1;
        if (mem_ack) begin
          ack_take  = 1'b1;
          state_nxt = DONE;
        end else if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
          tmo_take  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, RAM request level, timeout counter, read data and sticky error
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req         <= '0;
      mem_req     <= 1'b0;
      rdata       <= RDATA_IDLE;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      tmo_cnt     <= 16'd0;
    end else begin
      rdata_valid <= 1'b0;
      if (accept && !hit_take) begin
        req.addr <= REQ_ADDR_W'(addr);
        req.we   <= ~rnw;
        req.din  <= wdata;
        mem_req  <= 1'b1;
        tmo_cnt  <= 16'd0;
      end
      if (state == WAIT_ACK) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (ack_take) begin
        mem_req <= 1'b0;
        tmo_cnt <= 16'd0;
        if (is_read) begin
          rdata       <= mem_dout;
          rdata_valid <= 1'b1;
        end
      end
      if (tmo_take) begin
        mem_req <= 1'b0;
        tmo_cnt <= 16'd0;
        err     <= 1'b1;
        if (is_read) begin
          rdata       <= RDATA_IDLE;
          rdata_valid <= 1'b1;
        end
      end
      if (hit_take) begin
        rdata       <= hit_data;
        rdata_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mapper_ram_sequencer.sv
// tb/tb_mapper_ram_sequencer.sv - randomized self-checking bench for mapper_ram_sequencer
module tb_mapper_ram_sequencer;

  localparam int ADDR_W = 27;
  localparam int TMO    = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cpu_req = 1'b0;
  logic              ram_cs = 1'b0;
  logic              rnw = 1'b1;
  logic              flush = 1'b0;
  logic              mem_ack = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [7:0]        wdata = 8'h00;
  logic [7:0]        mem_dout = 8'h00;
  logic              cpu_wait, rdata_valid, err, mem_req, mem_we;
  logic [7:0]        rdata, mem_din;
  logic [ADDR_W-1:0] mem_addr;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_rdata = 8'hFF;
  logic       exp_err = 1'b0;
`ifdef MAPPER_RAM_READ_CACHE_EN
  logic              c_valid = 1'b0;
  logic [ADDR_W-1:0] c_tag = '0;
  logic [7:0]        c_data = 8'h00;
`endif

  always #5 clk = ~clk;

  mapper_ram_sequencer #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_req     (cpu_req),
    .ram_cs      (ram_cs),
    .rnw         (rnw),
    .addr        (addr),
    .wdata       (wdata),
    .flush       (flush),
    .cpu_wait    (cpu_wait),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .err         (err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_ack     (mem_ack),
    .mem_dout    (mem_dout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    cpu_req  = 1'b0;
    ram_cs   = 1'($urandom_range(0, 1));
    rnw      = 1'($urandom_range(0, 1));
    addr     = ADDR_W'($urandom);
    wdata    = 8'($urandom);
    mem_dout = 8'($urandom);
    mem_ack  = 1'b0;
    flush    = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 27'h0002000;
      1:       return 27'h0012345;
      2:       return 27'h0100000;
      default: return ADDR_W'($urandom);
    endcase
  endfunction

  // One CPU cycle that does not start a transaction; optional stray request, late ack or flush
  task automatic idle_cycle(input bit stray_req, input bit late_ack, input bit do_flush);
    next_cycle();
    drive_idle();
    if (stray_req) begin
      cpu_req = 1'b1;
      ram_cs  = 1'b0;
    end
    mem_ack = late_ack;
    flush   = do_flush;
`ifdef MAPPER_RAM_READ_CACHE_EN
    if (do_flush) c_valid = 1'b0;
`endif
    sample();
    check("idle_mem_req", mem_req, 0);
    check("idle_cpu_wait", cpu_wait, 0);
    check("idle_rvalid", rdata_valid, 0);
    check("idle_rdata", rdata, exp_rdata);
    check("idle_err", err, exp_err);
  endtask

  // Full CPU transaction; ack_at > TMO means the RAM port never answers
  task automatic run_txn(input bit rd, input logic [ADDR_W-1:0] a, input logic [7:0] wd,
                         input int ack_at, input logic [7:0] dout);
    bit hit;
    bit acked;
    int last;
    hit = 1'b0;
`ifdef MAPPER_RAM_READ_CACHE_EN
    hit = rd && c_valid && (c_tag == a);
`endif
    next_cycle();
    drive_idle();
    cpu_req = 1'b1;
    ram_cs  = 1'b1;
    rnw     = rd;
    addr    = a;
    wdata   = wd;
    sample();
    check("accept_cpu_wait", cpu_wait, 1);
    check("accept_mem_req", mem_req, 0);
    if (hit) begin
`ifdef MAPPER_RAM_READ_CACHE_EN
      exp_rdata = c_data;
`endif
      next_cycle();
      drive_idle();
      sample();
      check("hit_mem_req", mem_req, 0);
      check("hit_rvalid", rdata_valid, 1);
      check("hit_rdata", rdata, exp_rdata);
      check("hit_cpu_wait", cpu_wait, 0);
      return;
    end
    acked = (ack_at <= TMO);
    last  = acked ? ack_at : TMO;
    for (int c = 1; c <= last; c++) begin
      next_cycle();
      drive_idle();
      mem_ack = (c == ack_at);
      if (c == ack_at) mem_dout = dout;
      sample();
      check("wait_cpu_wait", cpu_wait, 1);
      check("wait_mem_req", mem_req, 1);
      check("wait_mem_we", mem_we, !rd);
      check("wait_mem_addr", mem_addr, a);
      check("wait_mem_din", mem_din, wd);
      check("wait_rvalid", rdata_valid, 0);
    end
    if (!acked) exp_err = 1'b1;
    if (rd) exp_rdata = acked ? dout : 8'hFF;
`ifdef MAPPER_RAM_READ_CACHE_EN
    if (acked && rd) begin
      c_valid = 1'b1;
      c_tag   = a;
      c_data  = dout;
    end else if (acked && c_valid && c_tag == a) begin
      c_data = wd;
    end
`endif
    next_cycle();
    drive_idle();
    sample();
    check("done_cpu_wait", cpu_wait, 0);
    check("done_mem_req", mem_req, 0);
    check("done_rvalid", rdata_valid, rd);
    check("done_rdata", rdata, exp_rdata);
    check("done_err", err, exp_err);
  endtask

  task automatic model_reset();
    exp_rdata = 8'hFF;
    exp_err   = 1'b0;
`ifdef MAPPER_RAM_READ_CACHE_EN
    c_valid = 1'b0;
`endif
  endtask

  // Reset asserted in the second WAIT_ACK cycle of a read that never gets an ack
  task automatic reset_mid_txn();
    next_cycle();
    drive_idle();
    cpu_req = 1'b1;
    ram_cs  = 1'b1;
    rnw     = 1'b1;
    addr    = 27'h0000777;
    next_cycle();
    drive_idle();
    next_cycle();
    drive_idle();
    reset_n = 1'b0;
    sample();
    check("rst_pre_mem_req", mem_req, 1);
    next_cycle();
    drive_idle();
    model_reset();
    sample();
    check("rst_mem_req", mem_req, 0);
    check("rst_cpu_wait", cpu_wait, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 8'hFF);
    reset_n = 1'b1;
  endtask

  initial begin
    drive_idle();
    ram_cs = 1'b0;
    repeat (3) next_cycle();
    sample();
    check("reset_cpu_wait", cpu_wait, 0);
    check("reset_rdata", rdata, 8'hFF);
    check("reset_rvalid", rdata_valid, 0);
    check("reset_err", err, 0);
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_din", mem_din, 0);
    next_cycle();
    reset_n = 1'b1;

    run_txn(1'b1, 27'h0012345, 8'h00, 3, 8'hA5);
    run_txn(1'b0, 27'h0100000, 8'h3C, 1, 8'h5A);
    idle_cycle(1'b1, 1'b0, 1'b0);
    idle_cycle(1'b1, 1'b0, 1'b0);
    run_txn(1'b1, 27'h0000100, 8'h00, TMO, 8'h6B);
    run_txn(1'b1, 27'h0000200, 8'h00, 100, 8'h00);
    idle_cycle(1'b0, 1'b0, 1'b0);
    idle_cycle(1'b0, 1'b0, 1'b0);
    idle_cycle(1'b0, 1'b1, 1'b0);
    run_txn(1'b0, 27'h0000300, 8'h44, 100, 8'h00);
    reset_mid_txn();

    run_txn(1'b1, 27'h0002000, 8'h00, 2, 8'h11);
    run_txn(1'b1, 27'h0002000, 8'h00, 2, 8'h99);
    run_txn(1'b0, 27'h0002000, 8'h22, 1, 8'h00);
    run_txn(1'b1, 27'h0002000, 8'h00, 2, 8'h98);
    idle_cycle(1'b0, 1'b0, 1'b1);
    run_txn(1'b1, 27'h0002000, 8'h00, 2, 8'h33);

    for (int i = 0; i < 80; i++) begin
      run_txn(1'($urandom_range(0, 1)), pick_addr(), 8'($urandom),
              int'($urandom_range(1, 10)), 8'($urandom));
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        idle_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
